// File: rtl/cmplx_mult_host.sv
// Hardware initiator for the cmplx_mult switch-style protocol: replays an operand
// pair as four timed handshake/data words, then samples the two result words.
module cmplx_mult_host #(
    parameter int WORD_W      = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] re_a,
    input  logic [WORD_W-1:0] im_a,
    input  logic [WORD_W-1:0] re_q,
    input  logic [WORD_W-1:0] im_q,
    output logic              hs_out,
    output logic [WORD_W-1:0] data_out,
    input  logic [WORD_W-1:0] led_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WORD_W-1:0] re_res,
    output logic [WORD_W-1:0] im_res
);

    localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_HIGH,
        S_RES_WAIT,
        S_IM_HIGH,
        S_TAIL,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [1:0]        idx_reg, idx_next;
    logic              hs_reg, hs_next;
    logic [WORD_W-1:0] data_reg, data_next;
    logic [WORD_W-1:0] re_reg, re_next;
    logic [WORD_W-1:0] im_reg, im_next;
    logic [WORD_W-1:0] op_reg [4];
    logic [WORD_W-1:0] op_in  [4];
    logic              accept;
    logic              phase_last;
    logic              timed;

    assign op_in[0] = re_a;
    assign op_in[1] = im_a;
    assign op_in[2] = re_q;
    assign op_in[3] = im_q;

    assign accept     = in_valid && (state_reg == S_IDLE);
    assign phase_last = (cnt_reg == CNT_LAST);
    assign timed      = (state_reg != S_IDLE) && (state_reg != S_DONE);

    // Operands are captured once at acceptance and never re-sampled mid-transaction.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_op
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    op_reg[gi] <= '0;
                end else if (accept) begin
                    op_reg[gi] <= op_in[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        re_next    = re_reg;
        im_next    = im_reg;
        case (state_reg)
            S_IDLE: begin
                if (in_valid) begin
                    state_next = S_GAP;
                    idx_next   = 2'd0;
                end
            end
            S_GAP: begin
                if (phase_last) state_next = S_HIGH;
            end
            S_HIGH: begin
                if (phase_last) begin
                    if (idx_reg == 2'd3) begin
                        state_next = S_RES_WAIT;
                    end else begin
                        state_next = S_GAP;
                        idx_next   = idx_reg + 2'd1;
                    end
                end
            end
            S_RES_WAIT: begin
                if (phase_last) begin
                    state_next = S_IM_HIGH;
                    re_next    = led_in;
                end
            end
            S_IM_HIGH: begin
                if (phase_last) begin
                    state_next = S_TAIL;
                    im_next    = led_in;
                end
            end
            S_TAIL: begin
                if (phase_last) state_next = S_DONE;
            end
            S_DONE: begin
                if (res_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        cnt_next = (timed && !phase_last) ? cnt_reg + CNT_W'(1) : '0;
        // Outputs are decoded from the next state so the registered lines line up with the state.
        hs_next   = (state_next == S_HIGH) || (state_next == S_IM_HIGH);
        data_next = (state_next == S_HIGH) ? op_reg[idx_next] : data_reg;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            hs_reg    <= 1'b0;
            data_reg  <= '0;
            re_reg    <= '0;
            im_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            hs_reg    <= hs_next;
            data_reg  <= data_next;
            re_reg    <= re_next;
            im_reg    <= im_next;
        end
    end

    assign in_ready  = (state_reg == S_IDLE);
    assign res_valid = (state_reg == S_DONE);
    assign hs_out    = hs_reg;
    assign data_out  = data_reg;
    assign re_res    = re_reg;
    assign im_res    = im_reg;

endmodule

// File: tb/tb_cmplx_mult_host.sv
// Directed bench for cmplx_mult_host with a behavioural cmplx_mult responder on each instance
// (HOLD_CYCLES=4 and HOLD_CYCLES=1).
module tb_cmplx_mult_host;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n = 1'b0;
    int         total = 0;
    int         bad   = 0;

    // Instance with default HOLD_CYCLES=4
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] re_a = 8'h00, im_a = 8'h00, re_q = 8'h00, im_q = 8'h00;
    logic       hs_out;
    logic [7:0] data_out;
    logic [7:0] led_in = 8'h00;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] re_res, im_res;

    // Instance with HOLD_CYCLES=1
    logic       in_valid_1 = 1'b0;
    logic       in_ready_1;
    logic [7:0] re_a_1 = 8'h00, im_a_1 = 8'h00, re_q_1 = 8'h00, im_q_1 = 8'h00;
    logic       hs_out_1;
    logic [7:0] data_out_1;
    logic [7:0] led_in_1 = 8'h00;
    logic       res_valid_1;
    logic       res_ready_1 = 1'b1;
    logic [7:0] re_res_1, im_res_1;

    cmplx_mult_host dut0 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .re_a(re_a), .im_a(im_a), .re_q(re_q), .im_q(im_q),
        .hs_out(hs_out), .data_out(data_out), .led_in(led_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .re_res(re_res), .im_res(im_res)
    );

    cmplx_mult_host #(.WORD_W(8), .HOLD_CYCLES(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid_1), .in_ready(in_ready_1),
        .re_a(re_a_1), .im_a(im_a_1), .re_q(re_q_1), .im_q(im_q_1),
        .hs_out(hs_out_1), .data_out(data_out_1), .led_in(led_in_1),
        .res_valid(res_valid_1), .res_ready(res_ready_1),
        .re_res(re_res_1), .im_res(im_res_1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] prod_re(input logic [7:0] ra, ia, rq, iq);
        int r;
        r = $signed(ra) * $signed(rq) - $signed(ia) * $signed(iq);
        return r[7:0];
    endfunction

    function automatic logic [7:0] prod_im(input logic [7:0] ra, ia, rq, iq);
        int r;
        r = $signed(ra) * $signed(iq) + $signed(ia) * $signed(rq);
        return r[7:0];
    endfunction

    // Responder for dut0: collects the four words on hs_out rising edges, then shows re, then im.
    logic [7:0] rw0 [4];
    int         pc0 = 0;
    int         g_cnt = 0;
    logic       prev_hs0 = 1'b0;
    bit         glitch_mode = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!reset_n || in_ready) begin
            pc0 = 0;
        end else if (hs_out && !prev_hs0) begin
            if (pc0 < 4) rw0[pc0] = data_out;
            pc0 = pc0 + 1;
            if (pc0 == 4) begin
                g_cnt  = 0;
                led_in = glitch_mode ? 8'h55 : prod_re(rw0[0], rw0[1], rw0[2], rw0[3]);
            end else if (pc0 == 5) begin
                led_in = prod_im(rw0[0], rw0[1], rw0[2], rw0[3]);
            end
        end else if (pc0 == 4) begin
            g_cnt = g_cnt + 1;
            // last RES_WAIT cycle for HOLD_CYCLES=4 is 2*4-1 cycles after the 4th rise
            if (glitch_mode && g_cnt == 7) led_in = 8'h33;
        end
        prev_hs0 = hs_out;
    end

    // Responder for dut1
    logic [7:0] rw1 [4];
    int         pc1 = 0;
    logic       prev_hs1 = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!reset_n || in_ready_1) begin
            pc1 = 0;
        end else if (hs_out_1 && !prev_hs1) begin
            if (pc1 < 4) rw1[pc1] = data_out_1;
            pc1 = pc1 + 1;
            if (pc1 == 4) led_in_1 = prod_re(rw1[0], rw1[1], rw1[2], rw1[3]);
            else if (pc1 == 5) led_in_1 = prod_im(rw1[0], rw1[1], rw1[2], rw1[3]);
        end
        prev_hs1 = hs_out_1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on dut0; optional hold of res_ready low with in_valid pulses.
    task automatic do_txn(input string tag, input logic [7:0] ra, ia, rq, iq,
                          input logic [7:0] exp_re, exp_im, input int hold);
        int   n = 0, pulses = 0, hs_hi = 0, unstable = 0, stable_err = 0;
        logic prev = 1'b0;
        logic [7:0] prev_d = 8'h00;
        logic [7:0] seen [5];
        for (int k = 0; k < 5; k++) seen[k] = 8'h00;
        re_a = ra; im_a = ia; re_q = rq; im_q = iq;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        re_a = 8'hEE; im_a = 8'hEE; re_q = 8'hEE; im_q = 8'hEE;
        check({tag, "_in_ready_busy"}, in_ready, 1'b0);
        while (n < 200) begin
            tick();
            n++;
            if (hs_out && !prev) begin
                if (pulses < 5) seen[pulses] = data_out;
                pulses++;
            end
            if (hs_out && prev && data_out != prev_d) unstable++;
            if (hs_out) hs_hi++;
            prev   = hs_out;
            prev_d = data_out;
            if (res_valid) break;
        end
        check({tag, "_latency"}, n, 44);
        check({tag, "_pulses"}, pulses, 5);
        check({tag, "_hs_cycles"}, hs_hi, 20);
        check({tag, "_data_stable"}, unstable, 0);
        check({tag, "_data_seq"}, {seen[0], seen[1], seen[2], seen[3]}, {ra, ia, rq, iq});
        check({tag, "_re_res"}, re_res, exp_re);
        check({tag, "_im_res"}, im_res, exp_im);
        for (int k = 0; k < hold; k++) begin
            in_valid = (k % 3 == 0);
            re_a = 8'(k); im_a = 8'(k + 1); re_q = 8'(k + 2); im_q = 8'(k + 3);
            tick();
            if (res_valid !== 1'b1 || in_ready !== 1'b0 || hs_out !== 1'b0 ||
                re_res !== exp_re || im_res !== exp_im) stable_err++;
        end
        in_valid = 1'b0;
        if (hold > 0) check({tag, "_hold_stable"}, stable_err, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_release_in_ready"}, in_ready, 1'b1);
        check({tag, "_release_res_valid"}, res_valid, 1'b0);
    endtask

    initial begin
        int n, first, second, idle_edge;
        logic [7:0] r1, i1, r2, i2;

        // Reset values
        reset_n = 1'b0;
        repeat (3) tick();
        check("rst_hs_out", hs_out, 1'b0);
        check("rst_data_out", data_out, 8'h00);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_re_res", re_res, 8'h00);
        check("rst_im_res", im_res, 8'h00);
        reset_n = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1'b1);
        $display("reset done");

        // Test 1: (1+2j)(3+4j) = -5+10j
        do_txn("t1", 8'h01, 8'h02, 8'h03, 8'h04, 8'hFB, 8'h0A, 0);
        $display("t1 txn re=%02h im=%02h", re_res, im_res);

        // Test 2: signed edge, (-128-128j)(1+0j) passes through bit-exact
        do_txn("t2", 8'h80, 8'h80, 8'h01, 8'h00, 8'h80, 8'h80, 0);
        $display("t2 txn re=%02h im=%02h", re_res, im_res);

        // Test 3: res_ready held low 20 cycles, in_valid pulses ignored; (3+1j)(2+5j) = 1+17j
        do_txn("t3", 8'h03, 8'h01, 8'h02, 8'h05, 8'h01, 8'h11, 20);
        $display("t3 txn re=%02h im=%02h", re_res, im_res);

        // Test 4: reset during WORD_HIGH[2], then a clean transaction
        re_a = 8'h11; im_a = 8'h22; re_q = 8'h33; im_q = 8'h44;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (22) tick();
        check("t4_hs_before_reset", hs_out, 1'b1);
        check("t4_data_before_reset", data_out, 8'h33);
        reset_n = 1'b0;
        tick();
        check("t4_rst_hs_out", hs_out, 1'b0);
        check("t4_rst_data_out", data_out, 8'h00);
        check("t4_rst_res_valid", res_valid, 1'b0);
        reset_n = 1'b1;
        tick();
        check("t4_in_ready", in_ready, 1'b1);
        do_txn("t4b", 8'h01, 8'h02, 8'h03, 8'h04, 8'hFB, 8'h0A, 0);
        $display("t4 txn re=%02h im=%02h", re_res, im_res);

        // Test 6: led_in shows 0x55 during RES_WAIT and 0x33 only on its last cycle; (2+3j)(4+5j) = -7+22j
        glitch_mode = 1'b1;
        do_txn("t6", 8'h02, 8'h03, 8'h04, 8'h05, 8'h33, 8'h16, 0);
        glitch_mode = 1'b0;
        $display("t6 txn re=%02h im=%02h", re_res, im_res);

        // Test 5: HOLD_CYCLES=1, back-to-back with res_ready tied high
        first = -1; second = -1; idle_edge = -1;
        r1 = 8'h00; i1 = 8'h00; r2 = 8'h00; i2 = 8'h00;
        re_a_1 = 8'h01; im_a_1 = 8'h02; re_q_1 = 8'h03; im_q_1 = 8'h04;
        in_valid_1 = 1'b1;
        tick();
        re_a_1 = 8'h10; im_a_1 = 8'h01; re_q_1 = 8'h02; im_q_1 = 8'hFF;
        n = 0;
        while (n < 60) begin
            tick();
            n++;
            if (in_ready_1 && first >= 0 && idle_edge < 0) idle_edge = n;
            if (res_valid_1) begin
                if (first < 0) begin
                    first = n; r1 = re_res_1; i1 = im_res_1;
                end else begin
                    second = n; r2 = re_res_1; i2 = im_res_1;
                    break;
                end
            end
        end
        in_valid_1 = 1'b0;
        check("t5_first_latency", first, 11);
        check("t5_idle_after_done", idle_edge, first + 1);
        check("t5_second_latency", second, idle_edge + 1 + 11);
        check("t5_first_re", r1, 8'hFB);
        check("t5_first_im", i1, 8'h0A);
        // (16+1j)(2-1j) = 33-14j
        check("t5_second_re", r2, 8'h21);
        check("t5_second_im", i2, 8'hF2);
        $display("t5 txn first=%0d re=%02h im=%02h second=%0d re=%02h im=%02h",
                 first, r1, i1, second, r2, i2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
